exe_stage: RTL and testbench

Execute stage of the 5-stage ARM pipeline, sitting between the ID/EX register and the MEM stage. It generates the second operand (Val2) and runs the ALU. It holds the NZCV status register and computes the branch target. Results are registered into the EX/MEM boundary, so downstream logic sees registered outputs one cycle after the instruction presents at the inputs.

---
 rtl/arm_pkg.sv | 43 ++++
 rtl/exe_stage_if.sv | 62 ++++++
 rtl/val2_generator.sv | 46 ++++
 rtl/exe_stage.sv | 153 +++++++++++++++
 tb/tb_exe_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: ALU opcodes, shift types,
// NZCV bit positions and forwarding-select codes.
package arm_pkg;

  localparam logic [3:0] STATUS_RST = 4'b0000;

  // ALU opcodes carried on Exe_CMD; unlisted codes are no-ops.
  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_t;

  // Register-operand shift types, from shift_operand[6:5].
  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_t;

  // Bit positions inside the {N,Z,C,V} status word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Operand forwarding selects; code 11 falls back to the register value.
  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_REG2 = 2'b11
  } fwd_sel_t;

endpackage

// File: rtl/exe_stage_if.sv
// Bus between ID/EX, the execute stage and EX/MEM.
// The forwarding signals exist only when FORWARDING_EN is defined.
interface exe_stage_if;
  import arm_pkg::*;

`ifdef FORWARDING_EN
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] MEM_fwd;
  logic [31:0] WB_fwd;
`endif
  logic        freeze;
  logic        WB_EN_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  logic        B_in;
  logic        S_in;
  logic        imm_in;
  logic [3:0]  Exe_CMD_in;
  logic [3:0]  Dest_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [31:0] PC_in;
  logic [31:0] Val_Rn_in;
  logic [31:0] Val_Rm_in;
  logic        carry_in;

  logic [3:0]  status;
  logic        Branch_taken;
  logic [31:0] Branch_address;
  logic        WB_EN;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_res;
  logic [31:0] Val_Rm;
  logic [3:0]  Dest;

  // Execute-stage side.
  modport slave (
`ifdef FORWARDING_EN
    input  sel_src1, sel_src2, MEM_fwd, WB_fwd,
`endif
    input  freeze, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, imm_in,
    input  Exe_CMD_in, Dest_in, shift_operand_in, signed_imm_24_in,
    input  PC_in, Val_Rn_in, Val_Rm_in, carry_in,
    output status, Branch_taken, Branch_address,
    output WB_EN, MEM_R_EN, MEM_W_EN, ALU_res, Val_Rm, Dest
  );

  // Pipeline-control side.
  modport master (
`ifdef FORWARDING_EN
    output sel_src1, sel_src2, MEM_fwd, WB_fwd,
`endif
    output freeze, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, imm_in,
    output Exe_CMD_in, Dest_in, shift_operand_in, signed_imm_24_in,
    output PC_in, Val_Rn_in, Val_Rm_in, carry_in,
    input  status, Branch_taken, Branch_address,
    input  WB_EN, MEM_R_EN, MEM_W_EN, ALU_res, Val_Rm, Dest
  );

endinterface

// File: rtl/val2_generator.sv
// Combinational second-operand generator: memory offset, rotated
// 8-bit immediate, or shifted Rm, in that priority order.
module val2_generator
  import arm_pkg::*;
(
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  input  logic [31:0] rm,
  output logic [31:0] val2
);

  logic [4:0]  shift_amt;
  logic [4:0]  rot_amt;
  logic [63:0] imm_dbl;
  logic [63:0] rm_dbl;
  logic [63:0] imm_rot;
  logic [63:0] rm_rot;

  assign shift_amt = shift_operand[11:7];
  assign rot_amt   = {shift_operand[11:8], 1'b0};
  // Rotates are done as a right shift of the value concatenated with itself.
  assign imm_dbl   = {24'd0, shift_operand[7:0], 24'd0, shift_operand[7:0]};
  assign rm_dbl    = {rm, rm};
  assign imm_rot   = imm_dbl >> rot_amt;
  assign rm_rot    = rm_dbl >> shift_amt;

  // Select the operand; an amount of 0 leaves Rm unchanged for every type.
  always_comb begin
    val2 = rm;
    if (mem_en) begin
      val2 = {20'd0, shift_operand};
    end else if (imm) begin
      val2 = imm_rot[31:0];
    end else begin
      case (shift_t'(shift_operand[6:5]))
        SHIFT_LSL: val2 = rm << shift_amt;
        SHIFT_LSR: val2 = rm >> shift_amt;
        SHIFT_ASR: val2 = $unsigned($signed(rm) >>> shift_amt);
        SHIFT_ROR: val2 = rm_rot[31:0];
        default:   val2 = rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand select, ALU, NZCV register, branch target and
// the EX/MEM pipeline register. Optional operand forwarding is enabled
// with the FORWARDING_EN macro.
module exe_stage
  import arm_pkg::*;
(
  input logic          clk,
  input logic          rst,
  exe_stage_if.slave   bus
);

  logic [31:0] rn;
  logic [31:0] rm;
  logic [31:0] val2;
  logic [31:0] alu_res;
  logic [3:0]  flags_next;
  logic [32:0] sum;
  logic        ovf;
  logic        op_valid;
  logic        op_arith;

  logic [3:0]  status_reg;
  logic        wb_en_reg;
  logic        mem_r_en_reg;
  logic        mem_w_en_reg;
  logic [31:0] alu_res_reg;
  logic [31:0] val_rm_reg;
  logic [3:0]  dest_reg;

`ifdef FORWARDING_EN
  // Pick Rn from the register file or a later stage.
  always_comb begin
    rn = bus.Val_Rn_in;
    case (fwd_sel_t'(bus.sel_src1))
      FWD_MEM: rn = bus.MEM_fwd;
      FWD_WB:  rn = bus.WB_fwd;
      default: rn = bus.Val_Rn_in;
    endcase
  end

  // Pick Rm the same way; it feeds both Val2 and the store data.
  always_comb begin
    rm = bus.Val_Rm_in;
    case (fwd_sel_t'(bus.sel_src2))
      FWD_MEM: rm = bus.MEM_fwd;
      FWD_WB:  rm = bus.WB_fwd;
      default: rm = bus.Val_Rm_in;
    endcase
  end
`else
  assign rn = bus.Val_Rn_in;
  assign rm = bus.Val_Rm_in;
`endif

  val2_generator u_val2 (
    .shift_operand (bus.shift_operand_in),
    .imm           (bus.imm_in),
    .mem_en        (bus.MEM_R_EN_in | bus.MEM_W_EN_in),
    .rm            (rm),
    .val2          (val2)
  );

  // ALU and next flags; subtracts are Rn + ~Val2 + carry so C means no borrow.
  always_comb begin
    alu_res    = '0;
    sum        = '0;
    ovf        = 1'b0;
    op_valid   = 1'b1;
    op_arith   = 1'b0;
    flags_next = status_reg;
    case (bus.Exe_CMD_in)
      EXE_MOV: alu_res = val2;
      EXE_MVN: alu_res = ~val2;
      EXE_ADD: begin
        sum      = {1'b0, rn} + {1'b0, val2};
        op_arith = 1'b1;
        ovf      = (rn[31] == val2[31]) && (sum[31] != rn[31]);
      end
      EXE_ADC: begin
        sum      = {1'b0, rn} + {1'b0, val2} + {32'd0, bus.carry_in};
        op_arith = 1'b1;
        ovf      = (rn[31] == val2[31]) && (sum[31] != rn[31]);
      end
      EXE_SUB: begin
        sum      = {1'b0, rn} + {1'b0, ~val2} + 33'd1;
        op_arith = 1'b1;
        ovf      = (rn[31] != val2[31]) && (sum[31] != rn[31]);
      end
      EXE_SBC: begin
        sum      = {1'b0, rn} + {1'b0, ~val2} + {32'd0, bus.carry_in};
        op_arith = 1'b1;
        ovf      = (rn[31] != val2[31]) && (sum[31] != rn[31]);
      end
      EXE_AND: alu_res = rn & val2;
      EXE_ORR: alu_res = rn | val2;
      EXE_EOR: alu_res = rn ^ val2;
      default: op_valid = 1'b0;
    endcase
    if (op_arith) begin
      alu_res = sum[31:0];
    end
    if (op_valid) begin
      flags_next[FLAG_N] = alu_res[31];
      flags_next[FLAG_Z] = (alu_res == 32'd0);
      if (op_arith) begin
        flags_next[FLAG_C] = sum[32];
        flags_next[FLAG_V] = ovf;
      end
    end
  end

  // NZCV register: updated by flag-setting instructions unless stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_reg <= STATUS_RST;
    end else if (bus.S_in && !bus.freeze) begin
      status_reg <= flags_next;
    end
  end

  // EX/MEM register: captures results every unstalled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_reg    <= 1'b0;
      mem_r_en_reg <= 1'b0;
      mem_w_en_reg <= 1'b0;
      alu_res_reg  <= '0;
      val_rm_reg   <= '0;
      dest_reg     <= '0;
    end else if (!bus.freeze) begin
      wb_en_reg    <= bus.WB_EN_in;
      mem_r_en_reg <= bus.MEM_R_EN_in;
      mem_w_en_reg <= bus.MEM_W_EN_in;
      alu_res_reg  <= alu_res;
      val_rm_reg   <= rm;
      dest_reg     <= bus.Dest_in;
    end
  end

  assign bus.status         = status_reg;
  assign bus.WB_EN          = wb_en_reg;
  assign bus.MEM_R_EN       = mem_r_en_reg;
  assign bus.MEM_W_EN       = mem_w_en_reg;
  assign bus.ALU_res        = alu_res_reg;
  assign bus.Val_Rm         = val_rm_reg;
  assign bus.Dest           = dest_reg;

  // Branch resolution is combinational so IF/ID can flush this cycle.
  assign bus.Branch_taken   = bus.B_in;
  assign bus.Branch_address = bus.PC_in +
                              {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios followed by random
// instructions, compared against an arithmetic reference model.
module tb_exe_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  exe_stage_if bus ();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state (EX/MEM contents and NZCV).
  logic [31:0] m_alu;
  logic [31:0] m_valrm;
  logic [3:0]  m_dest;
  logic [3:0]  m_status;
  logic        m_wb;
  logic        m_mr;
  logic        m_mw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rot_right(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
    return r;
  endfunction

  function automatic logic [31:0] model_val2(input logic [11:0] so, input logic imm,
                                             input logic mem, input logic [31:0] rmv);
    int amt;
    if (mem) return {20'd0, so};
    if (imm) return rot_right({24'd0, so[7:0]}, 2 * int'(so[11:8]));
    amt = int'(so[11:7]);
    case (so[6:5])
      2'b00:   return rmv << amt;
      2'b01:   return rmv >> amt;
      2'b10:   return $unsigned($signed(rmv) >>> amt);
      default: return rot_right(rmv, amt);
    endcase
  endfunction

  // Result and flags computed with wide integer arithmetic.
  task automatic model_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic [3:0] st,
                           output logic [31:0] res, output logic [3:0] st_new, output logic valid);
    longint ua, ub, sa, sb, s, full;
    logic c, v, arith;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = st[1]; v = st[0]; arith = 1'b1; valid = 1'b1; res = 32'd0;
    case (cmd)
      4'd2: begin full = ua + ub; s = sa + sb; c = (full >= 64'sh1_0000_0000); end
      4'd3: begin full = ua + ub + longint'(cin); s = sa + sb + longint'(cin);
                  c = (full >= 64'sh1_0000_0000); end
      4'd4: begin full = ua - ub; s = sa - sb; c = (ua >= ub); end
      4'd5: begin full = ua - ub - longint'(!cin); s = sa - sb - longint'(!cin);
                  c = (ua >= ub + longint'(!cin)); end
      default: begin full = 0; s = 0; arith = 1'b0; end
    endcase
    if (arith) begin
      res = full[31:0];
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else begin
      case (cmd)
        4'd1: res = b;
        4'd9: res = ~b;
        4'd6: res = a & b;
        4'd7: res = a | b;
        4'd8: res = a ^ b;
        default: valid = 1'b0;
      endcase
    end
    st_new = valid ? {res[31], res == 32'd0, c, v} : st;
  endtask

  task automatic model_reset();
    m_alu = '0; m_valrm = '0; m_dest = '0; m_status = 4'b0000;
    m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
  endtask

  task automatic set_defaults();
    bus.freeze = 0; bus.WB_EN_in = 0; bus.MEM_R_EN_in = 0; bus.MEM_W_EN_in = 0;
    bus.B_in = 0; bus.S_in = 0; bus.imm_in = 0; bus.Exe_CMD_in = 0; bus.Dest_in = 0;
    bus.shift_operand_in = 0; bus.signed_imm_24_in = 0; bus.PC_in = 0;
    bus.Val_Rn_in = 0; bus.Val_Rm_in = 0; bus.carry_in = 0;
`ifdef FORWARDING_EN
    bus.sel_src1 = 0; bus.sel_src2 = 0; bus.MEM_fwd = 0; bus.WB_fwd = 0;
`endif
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_alu"},    bus.ALU_res, m_alu);
    check({tag, "_valrm"},  bus.Val_Rm, m_valrm);
    check({tag, "_dest"},   {28'd0, bus.Dest}, {28'd0, m_dest});
    check({tag, "_ctl"},    {29'd0, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN},
                            {29'd0, m_wb, m_mr, m_mw});
    check({tag, "_status"}, {28'd0, bus.status}, {28'd0, m_status});
  endtask

  // One instruction: inputs already driven after a falling edge.
  task automatic step(input string tag);
    logic [31:0] a, b, v2, res, br;
    logic [3:0]  st_new;
    logic        valid;
    logic signed [23:0] off24;
    int          off;
    a = bus.Val_Rn_in; b = bus.Val_Rm_in;
`ifdef FORWARDING_EN
    if (bus.sel_src1 == 2'd1) a = bus.MEM_fwd; else if (bus.sel_src1 == 2'd2) a = bus.WB_fwd;
    if (bus.sel_src2 == 2'd1) b = bus.MEM_fwd; else if (bus.sel_src2 == 2'd2) b = bus.WB_fwd;
`endif
    v2 = model_val2(bus.shift_operand_in, bus.imm_in, bus.MEM_R_EN_in | bus.MEM_W_EN_in, b);
    model_alu(bus.Exe_CMD_in, a, v2, bus.carry_in, m_status, res, st_new, valid);
    off24 = bus.signed_imm_24_in;
    off = off24;
    br = bus.PC_in + 32'(off * 4);
    #1;
    check({tag, "_btaken"}, {31'd0, bus.Branch_taken}, {31'd0, bus.B_in});
    check({tag, "_baddr"},  bus.Branch_address, br);
    if (!bus.freeze) begin
      m_alu = res; m_valrm = b; m_dest = bus.Dest_in;
      m_wb = bus.WB_EN_in; m_mr = bus.MEM_R_EN_in; m_mw = bus.MEM_W_EN_in;
      if (bus.S_in && valid) m_status = st_new;
    end
    @(posedge clk); #1;
    check_outputs(tag);
    $display("[TB] %s: cmd=%h rn=%h val2=%h frz=%0d -> alu=%h nzcv=%b",
             tag, bus.Exe_CMD_in, a, v2, bus.freeze, bus.ALU_res, bus.status);
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    bus.freeze = ($urandom_range(0, 4) == 0);
    bus.WB_EN_in = 1'($urandom); bus.B_in = 1'($urandom); bus.S_in = 1'($urandom);
    bus.imm_in = 1'($urandom); bus.carry_in = 1'($urandom);
    bus.MEM_R_EN_in = ($urandom_range(0, 7) == 0);
    bus.MEM_W_EN_in = ($urandom_range(0, 7) == 0);
    bus.Exe_CMD_in = 4'($urandom_range(0, 15));
    bus.Dest_in = 4'($urandom);
    bus.shift_operand_in = 12'($urandom);
    bus.signed_imm_24_in = 24'($urandom);
    bus.PC_in = $urandom; bus.Val_Rn_in = $urandom; bus.Val_Rm_in = $urandom;
    if ($urandom_range(0, 3) == 0) bus.Val_Rm_in = bus.Val_Rn_in;
`ifdef FORWARDING_EN
    bus.sel_src1 = 2'($urandom); bus.sel_src2 = 2'($urandom);
    bus.MEM_fwd = $urandom; bus.WB_fwd = $urandom;
`endif
  endtask

  initial begin
    set_defaults();
    model_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // ADD immediate: 0xFF ror 4 = 0xF000000F, plus 5.
    set_defaults();
    bus.Val_Rn_in = 32'd5; bus.imm_in = 1; bus.shift_operand_in = 12'h2FF;
    bus.Exe_CMD_in = 4'd2; bus.S_in = 1; bus.WB_EN_in = 1; bus.Dest_in = 4'd3;
    step("add_imm");
    check("add_imm_const", bus.ALU_res, 32'hF0000014);
    check("add_imm_nzcv", {28'd0, bus.status}, 32'h8);

    // CMP equal operands, then SBC 10 - 4 - 1.
    set_defaults();
    bus.Val_Rn_in = 32'd3; bus.Val_Rm_in = 32'd3; bus.Exe_CMD_in = 4'd4; bus.S_in = 1;
    step("cmp");
    check("cmp_nzcv", {28'd0, bus.status}, 32'h6);
    set_defaults();
    bus.Val_Rn_in = 32'd10; bus.Val_Rm_in = 32'd4; bus.Exe_CMD_in = 4'd5; bus.WB_EN_in = 1;
    step("sbc");
    check("sbc_const", bus.ALU_res, 32'd5);

    // Signed overflow, then a logical op that must keep C and V.
    set_defaults();
    bus.Val_Rn_in = 32'h7FFFFFFF; bus.Val_Rm_in = 32'd1; bus.Exe_CMD_in = 4'd2; bus.S_in = 1;
    step("ovf");
    check("ovf_const", bus.ALU_res, 32'h80000000);
    check("ovf_nzcv", {28'd0, bus.status}, 32'h9);
    set_defaults();
    bus.Val_Rn_in = 32'hF0; bus.Val_Rm_in = 32'h0F; bus.Exe_CMD_in = 4'd6; bus.S_in = 1;
    step("and_keep_cv");
    check("and_nzcv", {28'd0, bus.status}, 32'h5);

    // Load address and a backward branch.
    set_defaults();
    bus.MEM_R_EN_in = 1; bus.WB_EN_in = 1; bus.Val_Rn_in = 32'h100;
    bus.shift_operand_in = 12'h804; bus.Exe_CMD_in = 4'd2;
    bus.B_in = 1; bus.PC_in = 32'h20; bus.signed_imm_24_in = 24'hFFFFFE;
    #1;
    check("branch_const", bus.Branch_address, 32'h18);
    step("ldr_branch");
    check("ldr_const", bus.ALU_res, 32'h904);

    // Freeze for three cycles with changing flag-setting inputs.
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      bus.freeze = 1; bus.S_in = 1; bus.Exe_CMD_in = 4'd2;
      step("freeze");
    end
    randomize_inputs();
    bus.freeze = 0; bus.S_in = 1;
    step("unfreeze");

`ifdef FORWARDING_EN
    set_defaults();
    bus.sel_src1 = 2'b01; bus.MEM_fwd = 32'd7; bus.Val_Rn_in = 32'd100;
    bus.imm_in = 1; bus.shift_operand_in = 12'h001; bus.Exe_CMD_in = 4'd2;
    step("fwd_mem");
    check("fwd_const", bus.ALU_res, 32'd8);
`endif

    // Random instruction stream.
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      step("rand");
    end

    // Asynchronous reset between clock edges.
    randomize_inputs();
    bus.freeze = 0; bus.S_in = 1; bus.Exe_CMD_in = 4'd9;
    step("pre_reset");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      randomize_inputs();
      step("post_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
